mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage sequencer between core and off-chip SRAM. Turns single-cycle mem_read/mem_write into a
//  multi-cycle SRAM handshake. Drives freeze to hold PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  Returns read data to the MEM/WB register's mem input on the DONE cycle.
// PARAMETERS
//  BASE_ADDR     1024  byte address mapped to SRAM word 0
//  SRAM_AW       16    SRAM word-address width
//  TURN_CYCLES   1     bus-turnaround cycles after each ack (0..15)
//  TIMEOUT_CYC   64    max ACCESS cycles before abort (MEM_TIMEOUT_EN only)
// PORTS
//  clk         in   1             clock, rising edge
//  rst         in   1             reset, asynchronous, active-high
//  mem_read    in   1             load in MEM stage (held stable while freeze=1)
//  mem_write   in   1             store in MEM stage (held stable while freeze=1)
//  addr        in   `WORD_WIDTH   byte address (ALU result)
//  wdata       in   `WORD_WIDTH   store data
//  rdata       out  `WORD_WIDTH   load data, registered; valid in DONE
//  freeze      out  1             pipeline stall, combinational
//  mem_err     out  1             sticky timeout flag
//  sram_req    out  1             access request, registered
//  sram_we     out  1             1=write, registered
//  sram_addr   out  SRAM_AW       word address, registered
//  sram_wdata  out  `WORD_WIDTH   write data, registered
//  sram_rdata  in   `WORD_WIDTH   read data, valid with sram_ack
//  sram_ack    in   1             single-cycle completion pulse
// BEHAVIOUR
//  Reset: async. state=IDLE; rdata, sram_req, sram_we, sram_addr, sram_wdata, mem_err=0.
//  - freeze forced 0 while rst=1. A reset mid-access drops sram_req immediately; the SRAM tolerates aborts.
//  States:
//  - IDLE: freeze = mem_read|mem_write. On a request, latch the address and go to ACCESS next edge.
//    * sram_req<=1; sram_we<=mem_write (write wins if both are set).
//    * sram_addr<=(addr-BASE_ADDR)>>2, truncated to SRAM_AW; sram_wdata<=wdata.
//  - ACCESS: freeze=1; hold sram_* stable until sram_ack.
//    * On ack: sram_req<=0; rdata<=sram_rdata on reads (rdata unchanged on writes).
//    * Next state is RECOVER if TURN_CYCLES>0, else DONE.
//    * An ack in the IDLE, RECOVER or DONE states is ignored.
//  - RECOVER: freeze=1; count TURN_CYCLES cycles, then go to DONE.
//  - DONE: freeze=0 for exactly 1 cycle; the pipeline advances at this edge; next state IDLE unconditionally.
//    The request still visible in DONE is not re-sampled.
//  Back-to-back accesses: a new request seen in IDLE freezes in that same cycle, with no extra gap.
//  Latency, with ack N cycles after sram_req rises: freeze high for 1+N+TURN_CYCLES cycles.
//  No address range check; an address below BASE_ADDR wraps modulo 2^SRAM_AW.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//  - ACCESS counts cycles. At TIMEOUT_CYC with no ack: sram_req<=0, mem_err<=1 (sticky until rst), go to RECOVER.
//  - rdata<=0 for an aborted read; the pipeline then completes normally.
//  MEM_TIMEOUT_EN undefined: ACCESS waits indefinitely; mem_err is tied to 0.
// STRUCTURE
//  settings.h: `WORD_WIDTH, `REG_FILE_DEPTH, plus new `MEM_ST_IDLE/ACCESS/RECOVER/DONE (2-bit encodings).
//  Sub-module mem_wait_counter: loadable down-counter with zero flag, shared by RECOVER and timeout.
// TESTING
//  1 Read, TURN=1, ack 3 cycles after req, sram_rdata=32'hCAFE0001:
//    freeze high 5 cycles; rdata=32'hCAFE0001 in DONE; sram_addr=(addr-1024)>>2.
//  2 Write addr=1032, wdata=32'h12345678, immediate ack:
//    sram_we=1, sram_addr=2, sram_wdata=32'h12345678; rdata unchanged.
//  3 Back-to-back load then store: exactly 1 freeze-low (DONE) cycle between the two accesses;
//    the second access starts in the cycle after DONE.
//  4 Async rst asserted in ACCESS: sram_req and freeze drop immediately; state=IDLE; outputs=0.
//  5 MEM_TIMEOUT_EN, TIMEOUT_CYC=8, no ack: abort after 8 ACCESS cycles; mem_err=1 and stays 1; rdata=0.
//  6 mem_read=mem_write=1, plus a stray sram_ack in IDLE: write is performed; the stray ack causes no transition.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared widths, FSM encodings and address helper for the MEM-stage SRAM sequencer.
// Optional build macro MEM_TIMEOUT_EN enables the ACCESS timeout in mem_access_ctrl.
package mem_access_ctrl_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned CNT_W      = 8;

    localparam logic [1:0] MEM_ST_IDLE    = 2'd0;
    localparam logic [1:0] MEM_ST_ACCESS  = 2'd1;
    localparam logic [1:0] MEM_ST_RECOVER = 2'd2;
    localparam logic [1:0] MEM_ST_DONE    = 2'd3;

    // Byte address to SRAM word index; addresses below base wrap naturally.
    function automatic logic [WORD_WIDTH-1:0] word_offset(
        input logic [WORD_WIDTH-1:0] byte_addr,
        input logic [WORD_WIDTH-1:0] base
    );
        return (byte_addr - base) >> 2;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// Loadable down-counter with zero flag; shared by the RECOVER turnaround and the ACCESS timeout.
module mem_wait_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && (count != '0))
            count <= count - W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: stretches single-cycle loads/stores into an SRAM req/ack handshake and freezes the pipeline.
// Define MEM_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles without ack and raise sticky mem_err.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned SRAM_AW     = 16,
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [WORD_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata,
    output logic                  freeze,
    output logic                  mem_err,
    output logic                  sram_req,
    output logic                  sram_we,
    output logic [SRAM_AW-1:0]    sram_addr,
    output logic [WORD_WIDTH-1:0] sram_wdata,
    input  logic [WORD_WIDTH-1:0] sram_rdata,
    input  logic                  sram_ack
);

    // Counter holds "remaining cycles minus one" so zero marks the final cycle of a phase.
    localparam logic [CNT_W-1:0] TURN_LOAD    = (TURN_CYCLES == 0) ? '0 : CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]       state;
    logic             req;
    logic             abort;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    assign req = mem_read | mem_write;

    assign freeze = !rst && (((state == MEM_ST_IDLE) && req) ||
                             (state == MEM_ST_ACCESS) ||
                             (state == MEM_ST_RECOVER));

`ifdef MEM_TIMEOUT_EN
    assign abort = (state == MEM_ST_ACCESS) && !sram_ack && cnt_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem_err <= 1'b0;
        else if (abort)
            mem_err <= 1'b1;
    end
`else
    assign abort   = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = TIMEOUT_LOAD;
        case (state)
            MEM_ST_IDLE:    cnt_load = req;
            MEM_ST_ACCESS: begin
                if (sram_ack || abort) begin
                    cnt_load = 1'b1;
                    cnt_val  = TURN_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            MEM_ST_RECOVER: cnt_dec = 1'b1;
            default: ;
        endcase
    end

    mem_wait_counter #(
        .W (CNT_W)
    ) u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= MEM_ST_IDLE;
            rdata      <= '0;
            sram_req   <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            case (state)
                MEM_ST_IDLE: begin
                    if (req) begin
                        state      <= MEM_ST_ACCESS;
                        sram_req   <= 1'b1;
                        sram_we    <= mem_write;
                        sram_addr  <= SRAM_AW'(word_offset(addr, WORD_WIDTH'(BASE_ADDR)));
                        sram_wdata <= wdata;
                    end
                end
                MEM_ST_ACCESS: begin
                    if (sram_ack) begin
                        sram_req <= 1'b0;
                        if (!sram_we)
                            rdata <= sram_rdata;
                        state <= (TURN_CYCLES > 0) ? MEM_ST_RECOVER : MEM_ST_DONE;
                    end else if (abort) begin
                        sram_req <= 1'b0;
                        if (!sram_we)
                            rdata <= '0;
                        state <= MEM_ST_RECOVER;
                    end
                end
                MEM_ST_RECOVER: begin
                    if (cnt_zero)
                        state <= MEM_ST_DONE;
                end
                default: state <= MEM_ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (TURN_CYCLES=1, TIMEOUT_CYC=8).
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata, rdata;
    logic        freeze, mem_err;
    logic        sram_req, sram_we;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;
    logic        sram_ack;

    int unsigned total = 0;
    int unsigned bad   = 0;

    int unsigned fz;
    logic        cap_we;
    logic [15:0] cap_addr;
    logic [31:0] cap_wd;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .BASE_ADDR   (1024),
        .SRAM_AW     (16),
        .TURN_CYCLES (1),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .freeze     (freeze),
        .mem_err    (mem_err),
        .sram_req   (sram_req),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_ack   (sram_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Presents a request and plays the SRAM side; returns in the first freeze-low (DONE) cycle.
    task automatic run_access(
        input  logic        rd,
        input  logic        wr,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  int unsigned ack_n,
        input  logic [31:0] rv,
        output int unsigned fzc,
        output logic        c_we,
        output logic [15:0] c_addr,
        output logic [31:0] c_wd
    );
        int unsigned acc;
        acc    = 0;
        fzc    = 0;
        c_we   = 1'b0;
        c_addr = '0;
        c_wd   = '0;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        #1;
        for (int i = 0; i < 200 && freeze; i++) begin
            fzc++;
            if (sram_req) begin
                acc++;
                if (acc == 1) begin
                    c_we   = sram_we;
                    c_addr = sram_addr;
                    c_wd   = sram_wdata;
                end
                if (acc == ack_n) begin
                    sram_ack   = 1'b1;
                    sram_rdata = rv;
                end
            end
            @(posedge clk);
            #1;
            sram_ack   = 1'b0;
            sram_rdata = '0;
            #1;
        end
    endtask

    task automatic idle_next;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        mem_read   = 1'b1;
        mem_write  = 1'b0;
        addr       = 32'd1044;
        wdata      = '0;
        sram_rdata = '0;
        sram_ack   = 1'b0;
        #1;
        check("rst_freeze", {31'd0, freeze}, 32'd0);
        check("rst_req", {31'd0, sram_req}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", {31'd0, mem_err}, 32'd0);
        mem_read = 1'b0;
        #11 rst = 1'b0;
        @(posedge clk);
        #1;

        // Read, ack on 3rd ACCESS cycle
        run_access(1'b1, 1'b0, 32'd1044, 32'd0, 3, 32'hCAFE0001, fz, cap_we, cap_addr, cap_wd);
        check("rd_freeze_cycles", fz, 32'd5);
        check("rd_we", {31'd0, cap_we}, 32'd0);
        check("rd_addr", {16'd0, cap_addr}, 32'd5);
        check("rd_rdata", rdata, 32'hCAFE0001);
        check("rd_done_req", {31'd0, sram_req}, 32'd0);
        idle_next();
        check("idle_freeze", {31'd0, freeze}, 32'd0);

        // Write, immediate ack
        run_access(1'b0, 1'b1, 32'd1032, 32'h12345678, 1, 32'hDEADBEEF, fz, cap_we, cap_addr, cap_wd);
        check("wr_freeze_cycles", fz, 32'd3);
        check("wr_we", {31'd0, cap_we}, 32'd1);
        check("wr_addr", {16'd0, cap_addr}, 32'd2);
        check("wr_wdata", cap_wd, 32'h12345678);
        check("wr_rdata_kept", rdata, 32'hCAFE0001);
        idle_next();

        // Back-to-back load then store, store below BASE_ADDR wraps
        run_access(1'b1, 1'b0, 32'd1048, 32'd0, 2, 32'h11112222, fz, cap_we, cap_addr, cap_wd);
        check("b2b_ld_cycles", fz, 32'd4);
        check("b2b_ld_rdata", rdata, 32'h11112222);
        @(posedge clk);
        #1;
        run_access(1'b0, 1'b1, 32'd1020, 32'hA5A5A5A5, 2, 32'h0, fz, cap_we, cap_addr, cap_wd);
        check("b2b_st_cycles", fz, 32'd4);
        check("b2b_st_addr_wrap", {16'd0, cap_addr}, 32'h0000FFFF);
        check("b2b_st_wdata", cap_wd, 32'hA5A5A5A5);
        check("b2b_st_rdata_kept", rdata, 32'h11112222);
        idle_next();

        // Stray ack in IDLE, then read+write together
        sram_ack = 1'b1;
        #1;
        check("stray_freeze", {31'd0, freeze}, 32'd0);
        @(posedge clk);
        #1;
        sram_ack = 1'b0;
        #1;
        check("stray_req", {31'd0, sram_req}, 32'd0);
        check("stray_freeze_after", {31'd0, freeze}, 32'd0);
        run_access(1'b1, 1'b1, 32'd1064, 32'h0F0F0F0F, 1, 32'h77777777, fz, cap_we, cap_addr, cap_wd);
        check("both_cycles", fz, 32'd3);
        check("both_we", {31'd0, cap_we}, 32'd1);
        check("both_addr", {16'd0, cap_addr}, 32'd10);
        check("both_wdata", cap_wd, 32'h0F0F0F0F);
        check("both_rdata_kept", rdata, 32'h11112222);
        idle_next();

`ifdef MEM_TIMEOUT_EN
        run_access(1'b1, 1'b0, 32'd1028, 32'd0, 1, 32'h0BADF00D, fz, cap_we, cap_addr, cap_wd);
        check("pre_to_rdata", rdata, 32'h0BADF00D);
        idle_next();
        run_access(1'b1, 1'b0, 32'd1028, 32'd0, 0, 32'd0, fz, cap_we, cap_addr, cap_wd);
        check("to_cycles", fz, 32'd10);
        check("to_err", {31'd0, mem_err}, 32'd1);
        check("to_rdata", rdata, 32'd0);
        idle_next();
        run_access(1'b0, 1'b1, 32'd1024, 32'h1, 1, 32'd0, fz, cap_we, cap_addr, cap_wd);
        check("to_after_cycles", fz, 32'd3);
        check("to_err_sticky", {31'd0, mem_err}, 32'd1);
        idle_next();
`else
        check("err_tied_low", {31'd0, mem_err}, 32'd0);
`endif

        // Async reset in the middle of ACCESS
        mem_read = 1'b1;
        addr     = 32'd1040;
        #1;
        @(posedge clk);
        #1;
        check("pre_rst_req", {31'd0, sram_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_req", {31'd0, sram_req}, 32'd0);
        check("midrst_freeze", {31'd0, freeze}, 32'd0);
        check("midrst_addr", {16'd0, sram_addr}, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_err", {31'd0, mem_err}, 32'd0);
        mem_read = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("postrst_freeze", {31'd0, freeze}, 32'd0);
        check("postrst_req", {31'd0, sram_req}, 32'd0);
        run_access(1'b1, 1'b0, 32'd1028, 32'd0, 1, 32'h55AA55AA, fz, cap_we, cap_addr, cap_wd);
        check("postrst_cycles", fz, 32'd3);
        check("postrst_addr", {16'd0, cap_addr}, 32'd1);
        check("postrst_rdata", rdata, 32'h55AA55AA);
        idle_next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
